// File: rtl/cpu_clk_pkg.sv
// Shared encodings and defaults for the CPU clock controller.
package cpu_clk_pkg;

  // Controller state; the encoding doubles as the ModeSel command encoding.
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_FAST = 2'b11
  } state_t;

  localparam int          DEF_DIV_WIDTH   = 32;
  localparam int          STEP_CNT_WIDTH  = 32;
  localparam logic [31:0] DEF_DIV         = 32'h05F5_E100;  // 1 strobe/s at 100 MHz
  localparam int          DEF_DEBOUNCE    = 1000000;        // 10 ms at 100 MHz

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability filter and
// rising-edge detector on the filtered level.
module button_debouncer
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Raw,
  output logic Level,
  output logic Rise
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the asynchronous button into the Clock domain.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= Raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive samples; any bounce back restarts the count.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync_b == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      stable_cnt <= '0;
      level      <= sync_b;
    end else begin
      stable_cnt <= stable_cnt + CNT_ONE;
    end
  end

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge Clock) begin
    if (!Reset) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign Level = level;
  assign Rise  = level & ~level_q;

endmodule

// File: rtl/cpu_clock_controller.sv
// Generates the single-cycle CPU advance strobe: divided run, full-speed run,
// debounced single step and halt (commanded or requested by the CPU).
module cpu_clock_controller
  import cpu_clk_pkg::*;
#(
  parameter int                   DIV_WIDTH       = DEF_DIV_WIDTH,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV     = DIV_WIDTH'(DEF_DIV),
  parameter int                   DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [1:0]                ModeSel,
  input  logic                      StepButton,
  input  logic                      DivLoad,
  input  logic [DIV_WIDTH-1:0]      DivValue,
  input  logic                      HaltRequest,
  output logic                      CpuEnable,
  output logic [STEP_CNT_WIDTH-1:0] StepCount,
  output logic [1:0]                State,
  output logic [DIV_WIDTH-1:0]      DivActive,
  output logic                      Heartbeat
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  // A ratio of zero behaves as one, including the reset default.
  localparam logic [DIV_WIDTH-1:0] RESET_DIV = (DEFAULT_DIV == '0) ? DIV_ONE : DEFAULT_DIV;

  state_t                      state;
  state_t                      next_state;
  logic                        halt_latched;
  logic                        halt_now;
  logic                        stay;
  logic [DIV_WIDTH-1:0]        period_cnt;
  logic [DIV_WIDTH-1:0]        div_active;
  logic [DIV_WIDTH-1:0]        div_pending;
  logic                        div_pending_valid;
  logic [DIV_WIDTH-1:0]        load_val;
  logic                        apply_ok;
  logic                        wrap;
  logic                        strobe;
  logic                        btn_level;
  logic                        btn_rise;
  logic                        cpu_enable;
  logic                        heartbeat;
  logic [STEP_CNT_WIDTH-1:0]   step_count;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .Clock (Clock),
    .Reset (Reset),
    .Raw   (StepButton),
    .Level (btn_level),
    .Rise  (btn_rise)
  );

  // Sticky CPU halt; only a pass through HALT mode clears it.
  always_ff @(posedge Clock) begin
    if (!Reset)                    halt_latched <= 1'b0;
    else if (HaltRequest)          halt_latched <= 1'b1;
    else if (ModeSel == ST_HALT)   halt_latched <= 1'b0;
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset) state <= ST_HALT;
    else        state <= next_state;
  end

  // Next state follows ModeSel unless a halt is pending or arriving now.
  always_comb begin
    halt_now   = halt_latched | HaltRequest;
    next_state = halt_now ? ST_HALT : state_t'(ModeSel);
  end

  // Strobe decode: no strobe in a cycle that leaves the current state, so a
  // halt or mode change suppresses the next advance and abandons the period.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    strobe = 1'b0;
    stay   = (next_state == state);
    wrap   = (state == ST_RUN) && (period_cnt >= (div_active - DIV_ONE));
    unique case (state)
      ST_HALT: strobe = 1'b0;
      ST_RUN:  strobe = wrap;
      ST_STEP: strobe = btn_rise & btn_level;
      ST_FAST: strobe = 1'b1;
    endcase
    strobe = strobe & stay;
  end

  // Period counter: runs only while staying in RUN, wraps at div_active-1.
  always_ff @(posedge Clock) begin
    if (!Reset)                          period_cnt <= '0;
    else if ((state == ST_RUN) && stay)  period_cnt <= wrap ? '0 : period_cnt + DIV_ONE;
    else                                 period_cnt <= '0;
  end

  // New ratios take effect at a period boundary, or at once outside RUN.
  always_comb begin
    load_val = (DivValue == '0) ? DIV_ONE : DivValue;
    apply_ok = wrap || (state != ST_RUN);
  end

  // Divide-ratio pending/active registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      div_active        <= RESET_DIV;
      div_pending       <= RESET_DIV;
      div_pending_valid <= 1'b0;
    end else if (DivLoad) begin
      if (apply_ok) begin
        div_active        <= load_val;
        div_pending_valid <= 1'b0;
      end else begin
        div_pending       <= load_val;
        div_pending_valid <= 1'b1;
      end
    end else if (div_pending_valid && apply_ok) begin
      div_active        <= div_pending;
      div_pending_valid <= 1'b0;
    end
  end

  // Registered strobe plus its strobe counter and heartbeat LED.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cpu_enable <= 1'b0;
      step_count <= '0;
      heartbeat  <= 1'b0;
    end else begin
      cpu_enable <= strobe;
      if (strobe) begin
        step_count <= step_count + STEP_CNT_WIDTH'(1);
        heartbeat  <= ~heartbeat;
      end
    end
  end

  assign CpuEnable = cpu_enable;
  assign StepCount = step_count;
  assign State     = state;
  assign DivActive = div_active;
  assign Heartbeat = heartbeat;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller. Expected strobe cycles are queued
// as stimulus is applied; a monitor pops one per observed CpuEnable.
module tb_cpu_clock_controller;

  logic        Clock;
  logic        Reset;
  logic [1:0]  ModeSel;
  logic        StepButton;
  logic        DivLoad;
  logic [31:0] DivValue;
  logic        HaltRequest;
  logic        CpuEnable;
  logic [31:0] StepCount;
  logic [1:0]  State;
  logic [31:0] DivActive;
  logic        Heartbeat;

  int cyc     = 0;
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int exp_q[$];

  cpu_clock_controller #(
    .DIV_WIDTH       (32),
    .DEFAULT_DIV     (32'd5),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ModeSel     (ModeSel),
    .StepButton  (StepButton),
    .DivLoad     (DivLoad),
    .DivValue    (DivValue),
    .HaltRequest (HaltRequest),
    .CpuEnable   (CpuEnable),
    .StepCount   (StepCount),
    .State       (State),
    .DivActive   (DivActive),
    .Heartbeat   (Heartbeat)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Cycle index: number of rising edges seen so far.
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Scoreboard: each observed strobe must match the oldest expected cycle.
  always @(negedge Clock) begin
    if (CpuEnable === 1'b1) begin
      int exp_c;
      exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      check("strobe_cycle", 64'(cyc), 64'(exp_c));
    end
  end

  initial begin
    int b;
    Reset = 1'b0; ModeSel = 2'b00; StepButton = 1'b0;
    DivLoad = 1'b0; DivValue = '0; HaltRequest = 1'b0;
    tick(3);

    // Reset state
    check("rst_cpu_enable", CpuEnable, 0);
    check("rst_step_count", StepCount, 0);
    check("rst_state",      State, 0);
    check("rst_div_active", DivActive, 5);
    check("rst_heartbeat",  Heartbeat, 0);
    Reset = 1'b1;
    tick(1);

    // RUN at ratio 5: first strobe 5 cycles after State=RUN, then every 5
    b = cyc;
    ModeSel = 2'b01;
    for (int k = 0; k < 4; k++) exp_q.push_back(b + 6 + 5 * k);
    tick(1);
    check("run_state", State, 1);
    tick(21);
    check("run_step_count", StepCount, 4);
    check("run_heartbeat",  Heartbeat, 0);
    check("run_drain",      exp_q.size(), 0);

    // Mid-period load of 2: current period completes, then every 2 cycles
    tick(1);
    DivLoad = 1'b1; DivValue = 32'd2;
    exp_q.push_back(b + 26); exp_q.push_back(b + 28); exp_q.push_back(b + 30);
    tick(1);
    DivLoad = 1'b0;
    check("div_pending_not_applied", DivActive, 5);
    tick(3);
    check("div_applied_2", DivActive, 2);
    tick(3);
    // Ratio 0 behaves as 1: strobe every cycle after the next wrap
    DivLoad = 1'b1; DivValue = 32'd0;
    for (int k = 0; k < 4; k++) exp_q.push_back(b + 32 + k);
    tick(1);
    DivLoad = 1'b0;
    tick(4);
    ModeSel = 2'b00;
    tick(1);
    check("run_to_halt_state", State, 0);
    check("div_applied_0_as_1", DivActive, 1);
    tick(2);
    check("div_drain", exp_q.size(), 0);
    check("div_step_count", StepCount, 11);
    check("div_heartbeat",  Heartbeat, 1);

    // STEP: clean press held 10 cycles -> one strobe 7 cycles after raw rise
    ModeSel = 2'b10;
    tick(2);
    b = cyc;
    StepButton = 1'b1;
    exp_q.push_back(b + 7);
    tick(10);
    StepButton = 1'b0;
    tick(12);
    check("step_drain", exp_q.size(), 0);
    check("step_count_press", StepCount, 12);

    // STEP: 2-cycle glitch is filtered out
    StepButton = 1'b1;
    tick(2);
    StepButton = 1'b0;
    tick(12);
    check("step_glitch", StepCount, 12);

    // Press accepted while in HALT is discarded, not replayed in STEP
    ModeSel = 2'b00;
    tick(1);
    StepButton = 1'b1;
    tick(10);
    ModeSel = 2'b10;
    tick(4);
    StepButton = 1'b0;
    tick(10);
    check("step_halt_press", StepCount, 12);
    ModeSel = 2'b00;
    tick(2);

    // FAST with HaltRequest in cycle t = b+5
    b = cyc;
    ModeSel = 2'b11;
    for (int k = 2; k <= 5; k++) exp_q.push_back(b + k);
    tick(5);
    HaltRequest = 1'b1;
    tick(1);
    HaltRequest = 1'b0;
    check("halt_state", State, 0);
    check("halt_no_strobe", CpuEnable, 0);
    tick(5);
    check("halt_sticky", State, 0);
    b = cyc;
    ModeSel = 2'b00;
    tick(1);
    ModeSel = 2'b11;
    exp_q.push_back(b + 3); exp_q.push_back(b + 4);
    tick(1);
    check("resume_state", State, 3);
    tick(2);
    ModeSel = 2'b00;
    tick(2);
    check("fast_drain", exp_q.size(), 0);
    check("fast_step_count", StepCount, 18);

    // Reset mid-period in RUN at ratio 3
    b = cyc;
    DivLoad = 1'b1; DivValue = 32'd3;
    tick(1);
    DivLoad = 1'b0;
    check("halt_load_immediate", DivActive, 3);
    ModeSel = 2'b01;
    exp_q.push_back(b + 5); exp_q.push_back(b + 8);
    tick(8);
    Reset = 1'b0;
    tick(1);
    check("rst2_cpu_enable", CpuEnable, 0);
    check("rst2_step_count", StepCount, 0);
    check("rst2_state",      State, 0);
    check("rst2_div_active", DivActive, 5);
    check("rst2_heartbeat",  Heartbeat, 0);
    check("rst2_drain",      exp_q.size(), 0);
    ModeSel = 2'b00;
    Reset = 1'b1;
    tick(1);

    // StepCount wraps from all-ones to zero
    force dut.step_count = 32'hFFFF_FFFF;
    tick(1);
    release dut.step_count;
    tick(1);
    b = cyc;
    ModeSel = 2'b11;
    exp_q.push_back(b + 2);
    tick(2);
    ModeSel = 2'b00;
    check("wrap_step_count", StepCount, 0);
    check("wrap_heartbeat",  Heartbeat, 1);
    tick(3);
    check("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
